// File: rtl/fc_dot_engine7_if.sv
// rtl/fc_dot_engine7_if.sv - Handshake, ROM and score signals of fc_dot_engine7.
// FC_ARGMAX_EN adds the pred_valid/pred_class prediction outputs.
interface fc_dot_engine7_if #(
    parameter int ADDR_WIDTH = 7,
    parameter int DATA_WIDTH = 144
);
    logic                  start;
    logic                  act_valid;
    logic                  act_ready;
    logic [DATA_WIDTH-1:0] act_data;
    logic [ADDR_WIDTH-1:0] addr_a;
    logic [ADDR_WIDTH-1:0] addr_b;
    logic [DATA_WIDTH-1:0] q_a;
    logic [DATA_WIDTH-1:0] q_b;
    logic                  out_valid;
    logic                  out_ready;
    logic [3:0]            out_idx;
    logic [15:0]           out_data;
    logic                  busy;
    logic                  done;
`ifdef FC_ARGMAX_EN
    logic                  pred_valid;
    logic [3:0]            pred_class;

    modport master (
        input  start, act_valid, act_data, q_a, q_b, out_ready,
        output act_ready, addr_a, addr_b, out_valid, out_idx, out_data, busy, done,
        output pred_valid, pred_class
    );
    modport slave (
        output start, act_valid, act_data, q_a, q_b, out_ready,
        input  act_ready, addr_a, addr_b, out_valid, out_idx, out_data, busy, done,
        input  pred_valid, pred_class
    );
`else
    modport master (
        input  start, act_valid, act_data, q_a, q_b, out_ready,
        output act_ready, addr_a, addr_b, out_valid, out_idx, out_data, busy, done
    );
    modport slave (
        output start, act_valid, act_data, q_a, q_b, out_ready,
        input  act_ready, addr_a, addr_b, out_valid, out_idx, out_data, busy, done
    );
`endif
endinterface

// File: rtl/fc_dot_engine7.sv
// rtl/fc_dot_engine7.sv - Layer-7 dot-product engine: activation buffer, paired ROM fetch, bias, Q8.8 saturation.
// Optional FC_ARGMAX_EN tracks the highest score and reports its class at done.
module fc_dot_engine7 #(
    parameter int ADDR_WIDTH    = 7,
    parameter int DATA_WIDTH    = 144,
    parameter int NUM_OUT       = 10,
    parameter int WORDS_PER_OUT = 6,
    parameter int BIAS_BASE     = 66,
    parameter int ACC_W         = 40
) (
    input logic              clk,
    input logic              rst_n,
    fc_dot_engine7_if.master bus
);
    localparam int LANES = DATA_WIDTH / 16;
    localparam int HALF  = WORDS_PER_OUT / 2;
    localparam int KW    = $clog2(WORDS_PER_OUT + 1);
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'(32767);
    localparam logic signed [ACC_W-1:0] SAT_MIN = -ACC_W'(32768);

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FETCH, S_BIAS, S_WAIT, S_EMIT} state_t;

    state_t                  state_q, state_d;
    logic [KW-1:0]           k_q, k_d;
    logic [3:0]              n_q, n_d;
    logic [1:0]              wcnt_q, wcnt_d;
    logic [DATA_WIDTH-1:0]   act_buf_q [WORDS_PER_OUT];
    logic [DATA_WIDTH-1:0]   act_buf_d [WORDS_PER_OUT];
    logic [ADDR_WIDTH-1:0]   addr_a_q, addr_a_d, addr_b_q, addr_b_d;
    logic                    rd_w_q, rd_w_d, rd_b_q, rd_b_d;
    logic [KW-1:0]           pair_q, pair_d;
    logic signed [31:0]      prod_q [2*LANES];
    logic signed [31:0]      prod_d [2*LANES];
    logic                    prod_vld_q, prod_vld_d, bias_vld_q, bias_vld_d;
    logic signed [ACC_W-1:0] bias_term_q, bias_term_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    done_q, done_d;

    logic                    acc_clr, accept;
    logic                    act_ready, out_valid;
    logic [DATA_WIDTH-1:0]   act_even, act_odd;
    logic signed [ACC_W-1:0] sum, shifted;
    logic [15:0]             score;

    always_comb begin
        state_d   = state_q;
        k_d       = k_q;
        n_d       = n_q;
        wcnt_d    = wcnt_q;
        act_buf_d = act_buf_q;
        addr_a_d  = addr_a_q;
        addr_b_d  = addr_b_q;
        acc_clr   = 1'b0;
        accept    = 1'b0;
        done_d    = 1'b0;
        act_ready = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    state_d = S_LOAD;
                    k_d     = '0;
                    n_d     = '0;
                end
            end
            S_LOAD: begin
                act_ready = 1'b1;
                if (bus.act_valid) begin
                    for (int w = 0; w < WORDS_PER_OUT; w++) begin
                        if (k_q == KW'(w)) act_buf_d[w] = bus.act_data;
                    end
                    if (k_q == KW'(WORDS_PER_OUT - 1)) begin
                        state_d = S_FETCH;
                        k_d     = '0;
                        acc_clr = 1'b1;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
                end
            end
            S_FETCH: begin
                addr_a_d = ADDR_WIDTH'(n_q) * ADDR_WIDTH'(WORDS_PER_OUT) + ADDR_WIDTH'({k_q, 1'b0});
                addr_b_d = addr_a_d + 1'b1;
                if (k_q == KW'(HALF - 1)) begin
                    state_d = S_BIAS;
                    k_d     = '0;
                end else begin
                    k_d = k_q + 1'b1;
                end
            end
            S_BIAS: begin
                addr_a_d = ADDR_WIDTH'(BIAS_BASE) + ADDR_WIDTH'(n_q);
                state_d  = S_WAIT;
                wcnt_d   = '0;
            end
            S_WAIT: begin
                // three drain cycles cover ROM latency, product stage and the bias add
                if (wcnt_q == 2'd2) state_d = S_EMIT;
                else                wcnt_d  = wcnt_q + 1'b1;
            end
            S_EMIT: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    accept = 1'b1;
                    if (n_q == 4'(NUM_OUT - 1)) begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        n_d     = n_q + 1'b1;
                        acc_clr = 1'b1;
                        state_d = S_FETCH;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rd_w_d     = (state_q == S_FETCH);
        rd_b_d     = (state_q == S_BIAS);
        pair_d     = (state_q == S_FETCH) ? k_q : pair_q;
        prod_vld_d = rd_w_q;
        bias_vld_d = rd_b_q;
        act_even   = '0;
        act_odd    = '0;
        for (int p = 0; p < HALF; p++) begin
            if (pair_q == KW'(p)) begin
                act_even = act_buf_q[2*p];
                act_odd  = act_buf_q[2*p+1];
            end
        end
        prod_d = prod_q;
        if (rd_w_q) begin
            for (int l = 0; l < LANES; l++) begin
                prod_d[l]       = $signed(bus.q_a[16*l +: 16]) * $signed(act_even[16*l +: 16]);
                prod_d[LANES+l] = $signed(bus.q_b[16*l +: 16]) * $signed(act_odd[16*l +: 16]);
            end
        end
        // bias is Q8.8; shifting by 8 lines it up with the Q16.16 products
        bias_term_d = rd_b_q ? {{(ACC_W-24){bus.q_a[DATA_WIDTH-1]}}, bus.q_a[DATA_WIDTH-1 -: 16], 8'h00}
                             : bias_term_q;
        sum = '0;
        for (int i = 0; i < 2*LANES; i++) begin
            sum = sum + {{(ACC_W-32){prod_q[i][31]}}, prod_q[i]};
        end
        acc_d = acc_q;
        if (acc_clr) begin
            acc_d = '0;
        end else begin
            if (prod_vld_q) acc_d = acc_d + sum;
            if (bias_vld_q) acc_d = acc_d + bias_term_q;
        end
        shifted = acc_q >>> 8;
        if (shifted > SAT_MAX)      score = 16'h7FFF;
        else if (shifted < SAT_MIN) score = 16'h8000;
        else                        score = shifted[15:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            k_q         <= '0;
            n_q         <= '0;
            wcnt_q      <= '0;
            addr_a_q    <= '0;
            addr_b_q    <= '0;
            rd_w_q      <= 1'b0;
            rd_b_q      <= 1'b0;
            pair_q      <= '0;
            prod_vld_q  <= 1'b0;
            bias_vld_q  <= 1'b0;
            bias_term_q <= '0;
            acc_q       <= '0;
            done_q      <= 1'b0;
            for (int w = 0; w < WORDS_PER_OUT; w++) act_buf_q[w] <= '0;
            for (int i = 0; i < 2*LANES; i++)       prod_q[i]    <= '0;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            n_q         <= n_d;
            wcnt_q      <= wcnt_d;
            addr_a_q    <= addr_a_d;
            addr_b_q    <= addr_b_d;
            rd_w_q      <= rd_w_d;
            rd_b_q      <= rd_b_d;
            pair_q      <= pair_d;
            prod_vld_q  <= prod_vld_d;
            bias_vld_q  <= bias_vld_d;
            bias_term_q <= bias_term_d;
            acc_q       <= acc_d;
            done_q      <= done_d;
            act_buf_q   <= act_buf_d;
            prod_q      <= prod_d;
        end
    end

    assign bus.act_ready = act_ready;
    assign bus.addr_a    = addr_a_d;
    assign bus.addr_b    = addr_b_d;
    assign bus.out_valid = out_valid;
    assign bus.out_idx   = n_q;
    assign bus.out_data  = out_valid ? score : 16'h0000;
    assign bus.busy      = (state_q != S_IDLE);
    assign bus.done      = done_q;

`ifdef FC_ARGMAX_EN
    logic signed [15:0] max_q, max_d;
    logic [3:0]         amax_q, amax_d, pred_class_q, pred_class_d;
    logic               pred_valid_q, pred_valid_d;

    always_comb begin
        max_d        = max_q;
        amax_d       = amax_q;
        pred_class_d = pred_class_q;
        pred_valid_d = 1'b0;
        if (state_q == S_IDLE && bus.start) pred_class_d = '0;
        // strict compare keeps the earlier (lower) index on ties
        if (accept && (n_q == 4'd0 || $signed(score) > max_q)) begin
            max_d  = $signed(score);
            amax_d = n_q;
        end
        if (done_d) begin
            pred_valid_d = 1'b1;
            pred_class_d = amax_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_q        <= '0;
            amax_q       <= '0;
            pred_class_q <= '0;
            pred_valid_q <= 1'b0;
        end else begin
            max_q        <= max_d;
            amax_q       <= amax_d;
            pred_class_q <= pred_class_d;
            pred_valid_q <= pred_valid_d;
        end
    end

    assign bus.pred_valid = pred_valid_q;
    assign bus.pred_class = pred_class_q;
`endif
endmodule

// File: tb/tb_fc_dot_engine7.sv
// tb/tb_fc_dot_engine7.sv - Directed-vector bench for fc_dot_engine7 with a registered dual-port ROM model.
module tb_fc_dot_engine7;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fc_dot_engine7_if #(.ADDR_WIDTH(7), .DATA_WIDTH(144)) bus ();
    fc_dot_engine7 u_dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    logic [143:0] rom [128];
    logic [15:0]  exp_sc [10];
    int           n_vec = 0;
    int           n_bad = 0;

    always @(posedge clk) begin
        bus.q_a <= rom[bus.addr_a];
        bus.q_b <= rom[bus.addr_b];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_rom(input logic [15:0] w, input logic [15:0] b_lo, input logic [15:0] b_hi);
        for (int a = 0; a < 128; a++) rom[a] = '0;
        for (int a = 0; a < 60; a++)  rom[a] = {9{w}};
        for (int n = 0; n < 10; n++)  rom[66+n] = {((n == 2 || n == 7) ? b_hi : b_lo), 128'h0};
    endtask

    task automatic set_exp(input logic [15:0] lo, input logic [15:0] hi);
        for (int n = 0; n < 10; n++) exp_sc[n] = (n == 2 || n == 7) ? hi : lo;
    endtask

    task automatic check_idle(input string tag);
        check_eq({tag, "_act_ready"}, 32'(bus.act_ready), 0);
        check_eq({tag, "_addr_a"},    32'(bus.addr_a),    0);
        check_eq({tag, "_addr_b"},    32'(bus.addr_b),    0);
        check_eq({tag, "_out_valid"}, 32'(bus.out_valid), 0);
        check_eq({tag, "_out_idx"},   32'(bus.out_idx),   0);
        check_eq({tag, "_out_data"},  32'(bus.out_data),  0);
        check_eq({tag, "_busy"},      32'(bus.busy),      0);
        check_eq({tag, "_done"},      32'(bus.done),      0);
    endtask

    task automatic run_job(input logic [15:0] act, input int stall_cls, input bit timing,
                           input bit gaps, input bit chk_pred);
        int cyc = 0, got = 0, ar = 0, ff = -1, stall_left = 0, dn = 0;
        bit fin = 0, stalled = 0;
        logic [15:0] cap_d = '0;
        logic [6:0]  cap_a = '0, cap_b = '0;
        @(negedge clk);
        bus.start = 1'b1; bus.act_valid = 1'b1; bus.act_data = {9{act}}; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (!fin && cyc < 2000) begin
            if (bus.act_ready) ar++;
            if (ff < 0 && bus.busy && !bus.act_ready && ar > 0) ff = cyc;
            if (timing && ff >= 0) begin
                if (cyc == ff)     begin check_eq("fetch0_a", 32'(bus.addr_a), 0);  check_eq("fetch0_b", 32'(bus.addr_b), 1); end
                if (cyc == ff + 1) begin check_eq("fetch1_a", 32'(bus.addr_a), 2);  check_eq("fetch1_b", 32'(bus.addr_b), 3); end
                if (cyc == ff + 2) begin check_eq("fetch2_a", 32'(bus.addr_a), 4);  check_eq("fetch2_b", 32'(bus.addr_b), 5); end
                if (cyc == ff + 3) begin check_eq("bias_a",   32'(bus.addr_a), 66); check_eq("bias_b",   32'(bus.addr_b), 5); end
                if (cyc == ff + 6) check_eq("early_valid", 32'(bus.out_valid), 0);
                if (cyc == ff + 7) check_eq("first_valid", 32'(bus.out_valid), 1);
            end
            if (bus.out_valid && int'(bus.out_idx) == stall_cls && !stalled) begin
                stalled = 1; stall_left = 5; bus.out_ready = 1'b0;
                cap_d = bus.out_data; cap_a = bus.addr_a; cap_b = bus.addr_b;
            end else if (stall_left > 0) begin
                check_eq("stall_valid", 32'(bus.out_valid), 1);
                check_eq("stall_idx",   32'(bus.out_idx),   32'(stall_cls));
                check_eq("stall_data",  32'(bus.out_data),  32'(cap_d));
                check_eq("stall_addr_a", 32'(bus.addr_a),   32'(cap_a));
                check_eq("stall_addr_b", 32'(bus.addr_b),   32'(cap_b));
                stall_left--;
                if (stall_left == 0) bus.out_ready = 1'b1;
            end
            if (bus.out_valid && bus.out_ready && got < 10) begin
                check_eq("score_idx",  32'(bus.out_idx),  32'(got));
                check_eq("score_data", 32'(bus.out_data), 32'(exp_sc[got]));
                got++;
            end
            if (bus.done) begin
                dn++;
                fin = 1;
                check_eq("done_after_last", 32'(got), 10);
`ifdef FC_ARGMAX_EN
                check_eq("pred_valid_at_done", 32'(bus.pred_valid), 1);
                if (chk_pred) check_eq("pred_class", 32'(bus.pred_class), 2);
`endif
            end
            if (gaps) bus.act_valid = (cyc % 3) != 1;
            @(negedge clk);
            cyc++;
        end
        check_eq("scores_accepted", 32'(got), 10);
        check_eq("done_pulses", 32'(dn), 1);
        if (timing) check_eq("act_ready_cycles", 32'(ar), 6);
        check_eq("done_one_cycle", 32'(bus.done), 0);
        check_eq("idle_after_done", 32'(bus.busy), 0);
`ifdef FC_ARGMAX_EN
        check_eq("pred_valid_one_cycle", 32'(bus.pred_valid), 0);
        if (chk_pred) check_eq("pred_class_held", 32'(bus.pred_class), 2);
`endif
        bus.act_valid = 1'b0;
    endtask

    task automatic abort_job(input logic [15:0] act);
        int cyc = 0;
        bit hit = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.act_valid = 1'b1; bus.act_data = {9{act}}; bus.out_ready = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        while (!hit && cyc < 2000) begin
            if (bus.busy && !bus.act_ready && bus.addr_a == 7'd24) hit = 1;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        check_eq("abort_reached_class4", 32'(hit), 1);
        check_eq("abort_out_idx", 32'(bus.out_idx), 4);
        rst_n = 1'b0;
        #1;
        check_idle("async_rst");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("no_done_in_reset", 32'(bus.done), 0);
        end
        bus.act_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check_eq("no_done_after_reset", 32'(bus.done), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0; bus.act_valid = 1'b0; bus.act_data = '0; bus.out_ready = 1'b0;
        fill_rom(16'h0000, 16'h0000, 16'h0000);
        @(negedge clk);
        @(negedge clk);
        check_idle("reset");
        rst_n = 1'b1;
        @(negedge clk);

        fill_rom(16'h0100, 16'h0100, 16'h0100);
        set_exp(16'h3700, 16'h3700);
        run_job(16'h0100, -1, 1'b1, 1'b0, 1'b0);
        run_job(16'h0100, 3, 1'b0, 1'b0, 1'b0);

        fill_rom(16'hFFFF, 16'h0000, 16'h0000);
        set_exp(16'hFFFF, 16'hFFFF);
        run_job(16'h0001, -1, 1'b0, 1'b1, 1'b0);

        fill_rom(16'hFF00, 16'h0002, 16'h0002);
        set_exp(16'hE502, 16'hE502);
        run_job(16'h0080, -1, 1'b0, 1'b1, 1'b0);

        fill_rom(16'h7FFF, 16'h7FFF, 16'h7FFF);
        set_exp(16'h7FFF, 16'h7FFF);
        run_job(16'h7FFF, -1, 1'b0, 1'b0, 1'b0);
        set_exp(16'h8000, 16'h8000);
        run_job(16'h8000, -1, 1'b0, 1'b0, 1'b0);

        fill_rom(16'h0100, 16'h0100, 16'h0100);
        abort_job(16'h0100);
        set_exp(16'h3700, 16'h3700);
        run_job(16'h0100, -1, 1'b1, 1'b0, 1'b0);

        fill_rom(16'h0100, 16'hCE00, 16'hCF00);
        set_exp(16'h0400, 16'h0500);
        run_job(16'h0100, -1, 1'b0, 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/fc_dot_engine7.md
Name: fc_dot_engine7

Overview:
- Final-layer compute stage that consumes the 144-bit dual-port weight ROM of layer 7.
- Buffers one activation vector of WORDS_PER_OUT packets; each packet holds 9 x 16-bit values.
- For each of NUM_OUT classes, drives the ROM address ports, computes a 9-wide dot product, adds the per-class bias, saturates, and streams out one 16-bit score per class.

Parameters:
- ADDR_WIDTH, 7, ROM address width.
- DATA_WIDTH, 144, ROM word width: 9 lanes x 16 bits.
- NUM_OUT, 10, number of classes/scores.
- WORDS_PER_OUT, 6, weight words per class. Must be even.
- BIAS_BASE, 66, ROM address of class-0 bias. The bias sits in word bits [143:128].
- ACC_W, 40, accumulator width.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; accepted only in IDLE.
- act_valid  in  1  activation packet valid.
- act_ready  out  1  high only in LOAD.
- act_data  in  144  9 x Q8.8 signed; lane i = bits [16i+15:16i].
- addr_a  out  ADDR_WIDTH  ROM port-a address.
- addr_b  out  ADDR_WIDTH  ROM port-b address.
- q_a  in  144  ROM port-a data, registered, 1-cycle latency.
- q_b  in  144  ROM port-b data, registered, 1-cycle latency.
- out_valid  out  1  score valid.
- out_ready  in  1  downstream accept.
- out_idx  out  4  class index of the current score.
- out_data  out  16  Q8.8 signed saturated score.
- busy  out  1  high whenever state is not IDLE.
- done  out  1  one-cycle pulse after the last score is accepted.

Behaviour:
- Reset: all outputs 0, state IDLE, activation buffer and accumulator cleared.
- Reset is asynchronous and takes effect mid-operation. Any partial load, accumulation or pending score is discarded; no done pulse.
- States:
  - IDLE. On start go to LOAD; clear k=0, n=0.
  - LOAD. act_ready=1. Each act_valid&act_ready cycle stores act_data into buf[k] and increments k. After buf[WORDS_PER_OUT-1] is stored, go to FETCH (k=0, acc=0). start is ignored outside IDLE.
  - FETCH. WORDS_PER_OUT/2 cycles. On cycle j: addr_a = n*WORDS_PER_OUT + 2j, addr_b = addr_a + 1.
  - BIAS. 1 cycle. addr_a = BIAS_BASE + n; addr_b holds its last value.
  - WAIT. Pipeline drain. EMIT is entered exactly WORDS_PER_OUT/2 + 4 cycles after the first FETCH cycle.
  - EMIT. out_valid=1 with out_idx=n. On out_valid&out_ready: if n = NUM_OUT-1, pulse done and go to IDLE; else n++, acc=0, go to FETCH.
- Pipeline:
  - ROM data arrives one cycle after the address.
  - Stage P registers 18 products (9 lanes x 2 ports). Each product is signed 16x16 = 32 bits.
  - Stage S sums all 18 products, sign-extended to ACC_W, into acc.
  - Bias word: acc += sign_extend(q_a[143:128]) << 8, aligned to the Q16.16 product scale.
- Result: out_data = sat16(acc >>> 8), arithmetic shift, truncation toward minus infinity. Clamp to 0x7FFF / 0x8000.
- Backpressure: out_data and out_idx are held stable while out_valid=1 and out_ready=0. No new ROM reads are issued in EMIT.
- Simultaneous events: a start pulse while busy is ignored. act_valid in any state other than LOAD is ignored (act_ready=0).
- Gaps in act_valid simply stall LOAD; there is no timeout.
- Outside FETCH/BIAS, addr_a and addr_b hold their last values.

Optional Feature:
- Macro FC_ARGMAX_EN.
- Defined:
  - Adds ports pred_valid (out, 1) and pred_class (out, 4).
  - The block tracks the maximum saturated score as each score is accepted. On ties, the lower index wins.
  - At the done pulse, pred_valid=1 for one cycle and pred_class holds the argmax until the next start. Reset value is 0.
- Undefined: the ports and the comparison logic are absent. All other behaviour is identical.

Test Plan:
- Unit dot product:
  - Stimulus: all activations 0x0100, every weight lane 0x0100, bias 0x0100, out_ready=1.
  - Response: 10 scores of 0x3700 (6*9 + 1 = 55.0), out_idx 0..9 in order, then one done pulse.
- Timing:
  - Stimulus: single start, act_valid continuously high.
  - Response: act_ready for exactly 6 cycles. addr_a/addr_b = (0,1),(2,3),(4,5) on consecutive cycles, then addr_a=66. First out_valid 7 cycles after the first FETCH cycle.
- Saturation:
  - Stimulus: weights and activations all 0x7FFF, bias 0x7FFF; then repeat with activations 0x8000.
  - Response: every score 0x7FFF on the first run and 0x8000 on the second.
- Backpressure:
  - Stimulus: out_ready held low for 5 cycles at class 3.
  - Response: out_valid, out_idx=3 and out_data are stable; addresses do not change; class 3 is accepted on the first cycle out_ready=1.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 during FETCH of class 4, then start again.
  - Response: all outputs are 0 immediately; no done pulse; the next run produces 10 correct scores starting at class 0.
- FC_ARGMAX_EN:
  - Stimulus: biases chosen so class 7 = 0x0500 and class 2 = 0x0500 are the maximum, other classes lower.
  - Response: pred_valid pulses together with done, and pred_class=2.
